// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature encoder emulator:
// FSM state encoding, Gray phase constants and the phase/period helpers.
package quad_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b01;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b10;

    // Must stay above the downstream decoder's 1000-clock stability filter.
    localparam int MIN_PERIOD_DEFAULT = 1002;

    // Forward walks PH0->PH1->PH2->PH3->PH0; reverse walks the same ring backwards.
    function automatic logic [1:0] phase_next(input logic [1:0] ph, input logic dir);
        logic [1:0] nxt;
        nxt = ph;
        if (dir) begin
            case (ph)
                PH0:     nxt = PH1;
                PH1:     nxt = PH2;
                PH2:     nxt = PH3;
                default: nxt = PH0;
            endcase
        end else begin
            case (ph)
                PH0:     nxt = PH3;
                PH3:     nxt = PH2;
                PH2:     nxt = PH1;
                default: nxt = PH0;
            endcase
        end
        return nxt;
    endfunction

    function automatic logic [15:0] eff_period(input logic [15:0] period,
                                               input logic [15:0] min_period);
        return (period < min_period) ? min_period : period;
    endfunction

endpackage

// File: rtl/quad_phase_step.sv
// Two-bit Gray stepper: moves one position along the quadrature ring
// whenever i_advance is high, in the direction given by i_dir.
module quad_phase_step
    import quad_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_advance,
    input  logic       i_dir,
    output logic [1:0] o_phase
);

    logic [1:0] r_phase;
    logic [1:0] w_phase_next;

    assign w_phase_next = phase_next(r_phase, i_dir);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH0;
        end else if (i_advance) begin
            r_phase <= w_phase_next;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/quad_emul.sv
// Quadrature encoder emulator: turns step commands into A/B Gray-coded
// edges with a clamped minimum spacing, tracking a signed position count.
module quad_emul
    import quad_pkg::*;
#(
    parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT,
    parameter int POS_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_dir,
    input  logic [15:0]      i_cmd_steps,
    input  logic [15:0]      i_cmd_period,
    input  logic             i_abort,
    output logic             o_ch_a,
    output logic             o_ch_b,
    output logic             o_step,
    output logic             o_done,
    output logic             o_busy,
    output logic [POS_W-1:0] o_pos_counter
);

    localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);

    state_t           r_state;
    logic             r_dir;
    logic [15:0]      r_steps;
    logic [15:0]      r_period;
    logic [15:0]      r_cnt;
    logic [POS_W-1:0] r_pos;
    logic             r_step;
    logic             r_done;

    logic [15:0]      w_eff_period;
    logic             w_fire;
    logic [1:0]       w_phase;

    assign w_eff_period = eff_period(i_cmd_period, MIN_P);

    // Abort wins over a step falling due on the same edge, so it gates the edge here.
    assign w_fire = (r_state == RUN) && !i_abort && (r_steps != 16'd0) && (r_cnt == 16'd0);

    quad_phase_step u_phase (
        .clk       (clk),
        .rst       (rst),
        .i_advance (w_fire),
        .i_dir     (r_dir),
        .o_phase   (w_phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dir    <= 1'b0;
            r_steps  <= 16'd0;
            r_period <= 16'd0;
            r_cnt    <= 16'd0;
            r_pos    <= '0;
            r_step   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_dir    <= i_cmd_dir;
                        r_steps  <= i_cmd_steps;
                        r_period <= w_eff_period;
                        r_cnt    <= w_eff_period - 16'd1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else if (r_steps == 16'd0) begin
                        // Zero-step command: one RUN cycle, no edge.
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else if (r_cnt == 16'd0) begin
                        r_cnt   <= r_period - 16'd1;
                        r_steps <= r_steps - 16'd1;
                        r_pos   <= r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
                        r_step  <= 1'b1;
                        if (r_steps == 16'd1) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cmd_ready   = (r_state == IDLE);
    assign o_busy        = (r_state == RUN);
    assign o_ch_a        = w_phase[1];
    assign o_ch_b        = w_phase[0];
    assign o_step        = r_step;
    assign o_done        = r_done;
    assign o_pos_counter = r_pos;

endmodule

// File: doc/quad_emul.md
# quad_emul

Quadrature encoder emulator: the transmit side of the external A/B wheel-sensor sync path. It accepts step commands and drives two-channel Gray-coded quadrature outputs with a programmable edge spacing. Its output can feed the quadrature sync decoder for loopback, and can stand in for a physical odometer in bench and field tests. A running position counter mirrors the count the decoder must report for the same edges.

## Interface
- `MIN_PERIOD`, 1002: minimum clocks between output edges. This exceeds the decoder's 1000-clock stability filter plus margin.
- `POS_W`, 32: width of the position counter.
- `clk`  in  1  system clock. This is the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `i_cmd_valid`  in  1  command present.
- `o_cmd_ready`  out  1  command can be accepted. High exactly when the FSM is in IDLE.
- `i_cmd_dir`  in  1  direction: 1 = forward (decoder counts up), 0 = reverse.
- `i_cmd_steps`  in  16  number of edges to emit.
- `i_cmd_period`  in  16  clocks between edges.
- `i_abort`  in  1  stop the current command.
- `o_ch_a`, `o_ch_b`  out  1 each  quadrature outputs, registered.
- `o_step`  out  1  one-cycle pulse in each cycle where the phase changes.
- `o_done`  out  1  one-cycle pulse when a command completes or is aborted.
- `o_busy`  out  1  FSM is in RUN.
- `o_pos_counter`  out  POS_W  signed position count, wraps modulo 2^POS_W.

## Operation
- FSM states are IDLE and RUN.
- IDLE → RUN on `i_cmd_valid & o_cmd_ready`. On that edge the block latches dir, steps and period, and loads the period counter with eff_period−1.
- eff_period = max(`i_cmd_period`, `MIN_PERIOD`). Any value below the minimum, including 0, is silently clamped.
- Phase {A,B} forward sequence: 00→01→11→10→00. Reverse follows the same sequence backwards.
- Each emitted edge changes exactly one channel. Two-bit jumps never occur.
- In RUN, the period counter decrements every clock. On the edge where it reads 0, the block:
  - advances the phase;
  - reloads the counter with eff_period−1;
  - decrements the remaining-step count;
  - increments `o_pos_counter` for forward or decrements it for reverse;
  - pulses `o_step`.
- On the final step, the FSM returns to IDLE on the same edge and `o_done` pulses.
- `i_cmd_steps` = 0: accepted, RUN is entered for exactly one cycle, then return to IDLE with an `o_done` pulse. No edge is emitted.
- `i_abort` in RUN: return to IDLE on the next edge and pulse `o_done`. The phase and position hold their values.
  - Abort has priority over a step due on the same edge: no edge is emitted.
  - `i_abort` in IDLE is ignored.
- The phase and position persist across commands. A reverse command after a forward one continues from the current phase.
- Reset forces: state IDLE, phase 00 (`o_ch_a` = `o_ch_b` = 0), `o_pos_counter` 0, `o_step`/`o_done`/`o_busy` 0, `o_cmd_ready` 1. Reset mid-RUN discards the command without an `o_done` pulse.

## Timing
- Command accepted at edge T0 → first phase change visible after edge T0+P, where P = eff_period.
- Edge k is visible after edge T0+k·P.
- For N steps: `o_done` is high in the cycle after edge T0+N·P, and `o_cmd_ready` is high in that same cycle.
  - A new command may be accepted on the next edge. Back-to-back commands therefore keep P spacing, plus one clock.
- `o_step`, `o_done` and `o_pos_counter` update on the same edge as the phase.
- A loopback decoder reports the matching count with its own filter latency (about 1001 clocks plus 2 register stages).
- Position arithmetic is POS_W-bit two's complement: 0x7FFF_FFFF + 1 → 0x8000_0000, and 0 − 1 → 0xFFFF_FFFF.

## Structure
- Package `quad_pkg` holds:
  - the state enum {IDLE, RUN};
  - phase constants PH0=2'b00, PH1=2'b01, PH2=2'b11, PH3=2'b10;
  - the `MIN_PERIOD` default.
- Sub-module `quad_phase_step`: a 2-bit Gray stepper with inputs `advance` and `dir` and output `{a,b}`, reset to PH0.
- The top level holds the FSM, the period counter, the step counter and the position counter.

## Test plan
- Forward, steps=8, period=1200 → 8 edges 1200 clocks apart, phase sequence 01,11,10,00,01,11,10,00, `o_pos_counter`=8, one `o_done`.
- Reverse, steps=3, period=5 → clamped to 1002 spacing, phases 10,11,01, `o_pos_counter`=−3 (0xFFFF_FFFD).
- Abort at the same edge as step 4 of 10 → exactly 3 edges, `o_pos_counter`=3, `o_done` one pulse, `o_busy` low the next cycle.
- steps=0 → no channel change, `o_done` pulse one cycle after acceptance, `o_cmd_ready` re-asserted.
- Reset asserted mid-RUN → next cycle A=B=0, position 0, `o_cmd_ready`=1, no `o_done`.
- Loopback to the decoder, +20 then −5 steps → decoder counter ends at 15 and matches `o_pos_counter`. No decoder count is produced by skipped states.
